// File: rtl/adat_framer_tx.sv
// ADAT lightpipe transmitter: builds 256-bit frames from a per-frame sample shadow and
// NRZI-codes them at one bit per mclk. Define ADAT_FRAMER_LOCK_EN for watchdog lock tracking.

module adat_framer_tx #(
  parameter int CHANNELS = 8,
  parameter int SAMPLE_W = 24
) (
  input  logic                         mclk,
  input  logic                         rst,
  input  logic                         wclk,
  input  logic [CHANNELS*SAMPLE_W-1:0] samples,
  input  logic [3:0]                   user,
  output logic                         adat,
  output logic                         frame_start,
  output logic                         locked
);

  localparam int         SLOTS    = 8;
  localparam int         SLOT_W   = 24;
  localparam logic [7:0] LAST_BIT = 8'd255;

  logic [7:0]                   bc_q, bc_d;
  logic                         adat_q;
  logic                         frame_start_q;
  logic                         locked_q, locked_d;
  logic                         wclk_q;
  logic [CHANNELS*SAMPLE_W-1:0] samples_q;
  logic [3:0]                   user_q;

  logic                         wclk_rise;
  logic                         last_bit;
  logic                         realign;
  logic                         capture;
  logic                         frame_bit;
  logic [SLOTS-1:0][SLOT_W-1:0] slot_w;
  logic [255:0]                 frame_w;

  assign wclk_rise = wclk & ~wclk_q;
  assign last_bit  = (bc_q == LAST_BIT);
  // An edge on the last bit is already in phase; anywhere else it restarts the frame.
  assign realign   = wclk_rise & ~last_bit;
  assign capture   = last_bit | wclk_rise;
  assign bc_d      = realign ? 8'd0 : bc_q + 8'd1;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    slot_w = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      slot_w[c][SLOT_W-1 -: SAMPLE_W] = samples_q[c*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_comb begin
    frame_w     = '0;
    frame_w[0]  = 1'b1;
    frame_w[11] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      frame_w[12+j] = user_q[3-j];
    end
    for (int c = 0; c < SLOTS; c++) begin
      for (int n = 0; n < 6; n++) begin
        frame_w[16+30*c+5*n] = 1'b1;
        for (int j = 0; j < 4; j++) begin
          frame_w[17+30*c+5*n+j] = slot_w[c][SLOT_W-1-4*n-j];
        end
      end
    end
  end

  assign frame_bit = frame_w[bc_q];

`ifdef ADAT_FRAMER_LOCK_EN
  localparam logic [8:0] WD_LIMIT = 9'd300;
  localparam logic [8:0] WD_LAST  = 9'd299;

  logic [8:0] wd_q, wd_d;
  logic [1:0] phase_cnt_q, phase_cnt_d;

  always_comb begin
    wd_d        = wd_q;
    phase_cnt_d = phase_cnt_q;
    locked_d    = locked_q;
    if (wclk_rise) begin
      wd_d = '0;
      if (last_bit) begin
        if (phase_cnt_q != 2'd2) phase_cnt_d = phase_cnt_q + 2'd1;
        if (phase_cnt_q != 2'd0) locked_d = 1'b1;
      end else begin
        phase_cnt_d = '0;
        locked_d    = 1'b0;
      end
    end else if (wd_q != WD_LIMIT) begin
      wd_d = wd_q + 9'd1;
      // Watchdog expiry drops lock; the frame keeps free-running regardless.
      if (wd_q == WD_LAST) begin
        phase_cnt_d = '0;
        locked_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      wd_q        <= '0;
      phase_cnt_q <= '0;
    end else begin
      wd_q        <= wd_d;
      phase_cnt_q <= phase_cnt_d;
    end
  end
`else
  assign locked_d = locked_q | wclk_rise;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge mclk) begin
    if (rst) begin
      bc_q          <= '0;
      adat_q        <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      wclk_q        <= 1'b0;
      // NOTE: the shadow is reset on purpose so the first frame after reset carries zero data.
      samples_q     <= '0;
      user_q        <= '0;
    end else begin
      bc_q          <= bc_d;
      adat_q        <= adat_q ^ frame_bit;
      frame_start_q <= (bc_d == 8'd0);
      locked_q      <= locked_d;
      wclk_q        <= wclk;
      if (capture) begin
        samples_q <= samples;
        user_q    <= user;
      end
    end
  end

  assign adat        = adat_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;

endmodule
